// File: rtl/tile_xfer_ctrl.sv
// Tile transfer controller: fills an 8x8 byte tile buffer from a source SRAM, then drains it as words.
// Optional abort port pair enabled by defining TILE_XFER_CTRL_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for start; all strobes low
// FILL  | 64 byte reads, k = 0..63
// FLUSH | last buffer write (k = 63), no read
// DRAIN | 32 word writes, w advances on wr_ready
// DONE  | one-cycle completion pulse
module tile_xfer_ctrl #(
  parameter int AW = 18,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          buf_wen,
  output logic [2:0]    buf_wi,
  output logic [2:0]    buf_wj,
  output logic [7:0]    buf_wdata,
  output logic [2:0]    buf_ri,
  output logic [1:0]    buf_rj,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  input  logic          wr_ready,
  output logic          busy,
  output logic          done
`ifdef TILE_XFER_CTRL_ABORT_EN
  ,
  input  logic          abort,
  output logic          aborted
`endif
);

  localparam int BYTES_PER_WORD = DW / 8;
  localparam int WORDS_PER_TILE = 64 / BYTES_PER_WORD;
  localparam logic [4:0] LAST_W = 5'(WORDS_PER_TILE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [5:0]    k, k_n, k_d;
  logic [4:0]    w, w_n;
  logic [AW-1:0] src_q, src_n, dst_q, dst_n;
  logic          wen_n;
`ifdef TILE_XFER_CTRL_ABORT_EN
  logic          abort_hit;
`endif

  always_comb begin
    state_n = state;
    k_n     = k;
    w_n     = w;
    src_n   = src_q;
    dst_n   = dst_q;
    wen_n   = rd_en;
`ifdef TILE_XFER_CTRL_ABORT_EN
    abort_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_n = FILL;
          k_n     = '0;
          w_n     = '0;
          src_n   = src_base;
          dst_n   = dst_base;
        end
      end
      FILL: begin
        k_n = k + 6'd1;
        if (k == 6'd63) state_n = FLUSH;
      end
      FLUSH: state_n = DRAIN;
      DRAIN: begin
        if (wr_ready) begin
          w_n = w + 5'd1;
          if (w == LAST_W) state_n = DONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifdef TILE_XFER_CTRL_ABORT_EN
    // An abort also drops the pending buffer write of the last read byte.
    if (abort && (state == FILL || state == FLUSH || state == DRAIN)) begin
      state_n   = IDLE;
      wen_n     = 1'b0;
      abort_hit = 1'b1;
    end
`endif
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      k       <= '0;
      k_d     <= '0;
      w       <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      buf_wen <= 1'b0;
      buf_ri  <= '0;
      buf_rj  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef TILE_XFER_CTRL_ABORT_EN
      aborted <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      k       <= k_n;
      k_d     <= k;
      w       <= w_n;
      src_q   <= src_n;
      dst_q   <= dst_n;
      rd_en   <= (state_n == FILL);
      rd_addr <= (state_n == FILL) ? src_n + AW'(k_n) : '0;
      buf_wen <= wen_n;
      buf_ri  <= (state_n == DRAIN) ? w_n[4:2] : '0;
      buf_rj  <= (state_n == DRAIN) ? w_n[1:0] : '0;
      wr_en   <= (state_n == DRAIN);
      wr_addr <= (state_n == DRAIN) ? dst_n + AW'(w_n) : '0;
      busy    <= (state_n != IDLE);
      done    <= (state_n == DONE);
`ifdef TILE_XFER_CTRL_ABORT_EN
      aborted <= abort_hit;
`endif
    end
  end

  // Source data arrives the cycle after the read, together with the delayed index.
  assign buf_wi    = buf_wen ? k_d[5:3] : '0;
  assign buf_wj    = buf_wen ? k_d[2:0] : '0;
  assign buf_wdata = buf_wen ? rd_data : '0;

endmodule

// File: tb/tb_tile_xfer_ctrl.sv
// Self-checking bench for tile_xfer_ctrl: directed table, corner sequences, randomized traffic vs. a transfer-level model.
module tb_tile_xfer_ctrl;
  localparam int AW = 18;

  logic          clock = 1'b0;
  logic          reset, start, wr_ready;
  logic [AW-1:0] src_base, dst_base;
  logic          rd_en, buf_wen, wr_en, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [7:0]    rd_data, buf_wdata;
  logic [2:0]    buf_wi, buf_wj, buf_ri;
  logic [1:0]    buf_rj;
  logic          abort;
`ifdef TILE_XFER_CTRL_ABORT_EN
  logic          aborted;
`endif

  always #5 clock = ~clock;

  tile_xfer_ctrl #(.AW(AW), .DW(16)) dut (
    .clock(clock), .reset(reset), .start(start),
    .src_base(src_base), .dst_base(dst_base),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .buf_wen(buf_wen), .buf_wi(buf_wi), .buf_wj(buf_wj), .buf_wdata(buf_wdata),
    .buf_ri(buf_ri), .buf_rj(buf_rj),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_ready(wr_ready),
    .busy(busy), .done(done)
`ifdef TILE_XFER_CTRL_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_done = -1;
  bit chk_on = 1'b0;

  // Transfer-level model: position within a transfer and number of words accepted.
  bit            m_act = 1'b0;
  int            m_t = 0;
  int            m_words = 0;
  logic [AW-1:0] m_src = '0, m_dst = '0;
  bit            m_abp = 1'b0;

  // Observed outputs of the last step, for table and hand checks.
  logic          o_rd_en, o_wen, o_wr_en, o_busy, o_done, o_ab;
  logic [AW-1:0] o_rd_addr, o_wr_addr;
  logic [2:0]    o_wi, o_wj, o_ri;
  logic [1:0]    o_rj;
  logic [7:0]    o_wdata;

  function automatic logic [7:0] src_byte(input logic [AW-1:0] a);
    logic [AW-1:0] s;
    s = a + 18'h40;
    return s[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit rst_i, input bit st_i, input bit rdy_i, input bit ab_i,
                      input logic [AW-1:0] sb_i, input logic [AW-1:0] db_i);
    bit            e_rd_en, e_wen, e_wr_en, e_done, e_busy;
    logic [AW-1:0] e_rd_addr, e_wr_addr;
    logic [2:0]    e_wi, e_wj, e_ri;
    logic [1:0]    e_rj;
    logic [7:0]    e_wdata;
    e_busy    = m_act;
    e_rd_en   = m_act && m_t >= 1 && m_t <= 64;
    e_rd_addr = e_rd_en ? m_src + AW'(m_t - 1) : '0;
    e_wen     = m_act && m_t >= 2 && m_t <= 65;
    e_wi      = e_wen ? 3'((m_t - 2) / 8) : 3'd0;
    e_wj      = e_wen ? 3'((m_t - 2) % 8) : 3'd0;
    e_wdata   = e_wen ? src_byte(m_src + AW'(m_t - 2)) : 8'd0;
    e_wr_en   = m_act && m_t >= 66 && m_words < 32;
    e_wr_addr = e_wr_en ? m_dst + AW'(m_words) : '0;
    e_ri      = e_wr_en ? 3'(m_words / 4) : 3'd0;
    e_rj      = e_wr_en ? 2'(m_words % 4) : 2'd0;
    e_done    = m_act && m_t >= 66 && m_words == 32;

    reset    = rst_i;
    start    = st_i;
    wr_ready = rdy_i;
    abort    = ab_i;
    src_base = sb_i;
    dst_base = db_i;
    rd_data  = e_wen ? src_byte(m_src + AW'(m_t - 2)) : 8'($urandom);

    @(negedge clock);
    o_rd_en = rd_en;  o_rd_addr = rd_addr; o_wen = buf_wen; o_wi = buf_wi; o_wj = buf_wj;
    o_wdata = buf_wdata; o_wr_en = wr_en; o_wr_addr = wr_addr; o_ri = buf_ri; o_rj = buf_rj;
    o_busy = busy; o_done = done;
`ifdef TILE_XFER_CTRL_ABORT_EN
    o_ab = aborted;
`else
    o_ab = 1'b0;
`endif
    if (chk_on) begin
      chk("busy", 32'(o_busy), 32'(e_busy));
      chk("rd_en", 32'(o_rd_en), 32'(e_rd_en));
      chk("rd_addr", 32'(o_rd_addr), 32'(e_rd_addr));
      chk("buf_wen", 32'(o_wen), 32'(e_wen));
      chk("buf_wi", 32'(o_wi), 32'(e_wi));
      chk("buf_wj", 32'(o_wj), 32'(e_wj));
      chk("buf_wdata", 32'(o_wdata), 32'(e_wdata));
      chk("wr_en", 32'(o_wr_en), 32'(e_wr_en));
      chk("wr_addr", 32'(o_wr_addr), 32'(e_wr_addr));
      chk("buf_ri", 32'(o_ri), 32'(e_ri));
      chk("buf_rj", 32'(o_rj), 32'(e_rj));
      chk("done", 32'(o_done), 32'(e_done));
`ifdef TILE_XFER_CTRL_ABORT_EN
      chk("aborted", 32'(o_ab), 32'(m_abp));
`endif
    end
    if (o_done === 1'b1) last_done = cyc;

    @(posedge clock);
    #1;
    m_abp = 1'b0;
    if (rst_i) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (st_i) begin
        m_act = 1'b1; m_t = 1; m_words = 0; m_src = sb_i; m_dst = db_i;
      end
`ifdef TILE_XFER_CTRL_ABORT_EN
    end else if (ab_i && !e_done) begin
      m_act = 1'b0;
      m_abp = 1'b1;
`endif
    end else if (e_done) begin
      m_act = 1'b0;
    end else begin
      if (e_wr_en && rdy_i) m_words++;
      m_t++;
    end
  endtask

  typedef struct {
    int            cyc;
    bit            st;
    bit            rdy;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wen;
    logic [2:0]    wi, wj;
    logic [7:0]    wdata;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          busy, done;
  } vec_t;

  localparam int NV = 10;
  vec_t tv[NV];

  initial begin
    int ti;
    bit s, r, rst, ab;
    tv[0] = '{0,  1, 1, 0, 18'h00000, 0, 0, 0, 8'h00, 0, 18'h00000, 0, 0};
    tv[1] = '{1,  0, 1, 1, 18'h00100, 0, 0, 0, 8'h00, 0, 18'h00000, 1, 0};
    tv[2] = '{2,  0, 1, 1, 18'h00101, 1, 0, 0, 8'h40, 0, 18'h00000, 1, 0};
    tv[3] = '{11, 0, 1, 1, 18'h0010A, 1, 1, 1, 8'h49, 0, 18'h00000, 1, 0};
    tv[4] = '{64, 0, 1, 1, 18'h0013F, 1, 7, 6, 8'h7E, 0, 18'h00000, 1, 0};
    tv[5] = '{65, 0, 1, 0, 18'h00000, 1, 7, 7, 8'h7F, 0, 18'h00000, 1, 0};
    tv[6] = '{66, 0, 1, 0, 18'h00000, 0, 0, 0, 8'h00, 1, 18'h00200, 1, 0};
    tv[7] = '{97, 0, 1, 0, 18'h00000, 0, 0, 0, 8'h00, 1, 18'h0021F, 1, 0};
    tv[8] = '{98, 0, 1, 0, 18'h00000, 0, 0, 0, 8'h00, 0, 18'h00000, 1, 1};
    tv[9] = '{99, 0, 1, 0, 18'h00000, 0, 0, 0, 8'h00, 0, 18'h00000, 0, 0};

    reset = 1'b1; start = 1'b0; wr_ready = 1'b1; abort = 1'b0;
    src_base = '0; dst_base = '0; rd_data = '0;
    @(posedge clock);
    #1;
    step(1, 1, 1, 1, 18'h1, 18'h2);
    chk_on = 1'b1;
    step(1, 0, 1, 0, '0, '0);
    step(0, 0, 1, 0, '0, '0);

    // Basic transfer driven from the table.
    ti = 0;
    for (int c = 0; c < 100; c++) begin
      s = 1'b0; r = 1'b1;
      if (ti < NV && tv[ti].cyc == c) begin s = tv[ti].st; r = tv[ti].rdy; end
      cyc = c;
      step(0, s, r, 0, 18'h00100, 18'h00200);
      if (ti < NV && tv[ti].cyc == c) begin
        chk("tbl_rd_en", 32'(o_rd_en), 32'(tv[ti].rd_en));
        chk("tbl_rd_addr", 32'(o_rd_addr), 32'(tv[ti].rd_addr));
        chk("tbl_wen", 32'(o_wen), 32'(tv[ti].wen));
        chk("tbl_wi", 32'(o_wi), 32'(tv[ti].wi));
        chk("tbl_wj", 32'(o_wj), 32'(tv[ti].wj));
        chk("tbl_wdata", 32'(o_wdata), 32'(tv[ti].wdata));
        chk("tbl_wr_en", 32'(o_wr_en), 32'(tv[ti].wr_en));
        chk("tbl_wr_addr", 32'(o_wr_addr), 32'(tv[ti].wr_addr));
        chk("tbl_busy", 32'(o_busy), 32'(tv[ti].busy));
        chk("tbl_done", 32'(o_done), 32'(tv[ti].done));
        ti++;
      end
    end

    // Backpressure on word 5 for three cycles.
    last_done = -1;
    for (int c = 0; c < 106; c++) begin
      cyc = c;
      step(0, c == 0, !(c >= 71 && c <= 73), 0, 18'h00100, 18'h00200);
      if (c == 74) begin
        chk("bp_wr_addr_held", 32'(o_wr_addr), 32'h205);
        chk("bp_ri_held", 32'(o_ri), 32'd1);
        chk("bp_rj_held", 32'(o_rj), 32'd1);
      end
    end
    chk("bp_done_cycle", 32'(last_done), 32'd101);

    // Source address wrap and an ignored start mid-fill.
    last_done = -1;
    for (int c = 0; c < 100; c++) begin
      cyc = c;
      step(0, c == 0 || c == 40, 1, 0, (c == 40) ? 18'h0AAAA : 18'h3FFF0, 18'h01000);
      if (c == 16) chk("wrap_rd_addr_hi", 32'(o_rd_addr), 32'h3FFFF);
      if (c == 17) chk("wrap_rd_addr_lo", 32'(o_rd_addr), 32'h00000);
    end
    chk("wrap_done_cycle", 32'(last_done), 32'd98);

    // Reset in DRAIN at w=10 abandons the transfer.
    last_done = -1;
    for (int c = 0; c < 82; c++) begin
      cyc = c;
      step(c == 76, c == 0, 1, 0, 18'h00300, 18'h00400);
      if (c == 77) begin
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_wr_en", 32'(o_wr_en), 32'd0);
      end
    end
    chk("rst_no_done", 32'(last_done), 32'hFFFF_FFFF);
    for (int c = 0; c < 100; c++) begin
      cyc = c;
      step(0, c == 0, 1, 0, 18'h00300, 18'h00400);
    end
    chk("rst_restart_done", 32'(last_done), 32'd98);

`ifdef TILE_XFER_CTRL_ABORT_EN
    last_done = -1;
    for (int c = 0; c < 40; c++) begin
      cyc = c;
      step(0, c == 0, 1, c == 30, 18'h00100, 18'h00200);
      if (c == 31) begin
        chk("abort_pulse", 32'(o_ab), 32'd1);
        chk("abort_idle", 32'(o_busy), 32'd0);
      end
    end
    chk("abort_no_done", 32'(last_done), 32'hFFFF_FFFF);
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 2500; c++) begin
      cyc = c;
      rst = ($urandom_range(0, 399) == 0);
      s   = m_act ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 9) < 7);
      ab  = ($urandom_range(0, 249) == 0);
      step(rst, s, r, ab, AW'($urandom), AW'($urandom));
    end
    for (int c = 0; c < 300 && m_act; c++) begin
      cyc = c;
      step(0, 0, 1, 0, '0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
